cb_deseg: RTL
=============

CB_DESEG -- requirements
Module: cb_deseg

Interface
REQ-001 The module SHALL have parameter K_SMALL, default 40, meaning the code block length in bits (filler + data + CRC) when in_size=0.
REQ-002 The module SHALL have parameter K_LARGE, default 6144, meaning the code block length in bits when in_size=1.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port in_data, input, 1 bit: serial code block bit.
REQ-006 The module SHALL have port in_valid, input, 1 bit: in_data and the flags are valid this cycle; low means stall, with no state change.
REQ-007 The module SHALL have ports in_start, in_stop, in_filling and in_crc, each input, 1 bit: first bit of block, last bit of block, filler bit, and CRC bit, respectively.
REQ-008 The module SHALL have port in_size, input, 1 bit: block size select, sampled with in_start.
REQ-009 The module SHALL have ports tb_data and tb_valid, each output, 1 bit: the recovered transport block bit stream and its qualifier.
REQ-010 The module SHALL have ports blk_done and blk_crc_ok, each output, 1 bit: a one-cycle end-of-block pulse, and the CRC result qualified by blk_done.
REQ-011 The module SHALL have ports err_len and err_proto, each output, 1 bit: one-cycle pulses flagging a length mismatch and a flag-sequence violation.

Function
REQ-012 The module SHALL act as the receive-side inverse of code block segmentation: strip filler bits, check and strip CRC24B, and output only data bits.
REQ-013 The FSM SHALL have states IDLE, FILL, DATA, CRC and DONE; all transitions SHALL occur only on cycles with in_valid=1.
REQ-014 In IDLE, a bit with in_start=1 SHALL be accepted as the first bit, latch in_size, clear the bit counter and CRC register, and enter FILL, DATA or CRC according to that bit's flags.
REQ-015 In IDLE, a bit with in_start=0 SHALL be discarded with an err_proto pulse.
REQ-016 Flag order SHALL be FILL*, then DATA*, then CRC, with exactly 24 CRC bits; in_filling and in_crc both high SHALL be a protocol error.
REQ-017 A filler bit after a data bit, or a filler or data bit after a CRC bit, SHALL pulse err_proto and force the block result to blk_crc_ok=0.
REQ-018 CRC24B, with g = D^24+D^23+D^6+D^5+D+1, SHALL be computed by a serial LFSR initialised to 0, non-inverted, MSB first.
REQ-019 Every accepted bit SHALL be shifted into the LFSR, with filler bits shifted in as 0 regardless of in_data.
REQ-020 blk_crc_ok SHALL be 1 only if the LFSR remainder is 0 after the last bit, no protocol error occurred, and the CRC bit count equals 24.
REQ-021 Data bits SHALL appear on tb_data with tb_valid=1 exactly one cycle after acceptance.
REQ-022 Filler and CRC bits SHALL never assert tb_valid.
REQ-023 The 13-bit bit counter SHALL count every accepted bit of the block.
REQ-024 On the in_stop bit, if the count differs from K_SMALL or K_LARGE (selected by the latched size), err_len SHALL pulse and blk_crc_ok SHALL be 0.
REQ-025 If the counter reaches K_LARGE+1 before in_stop, the block SHALL be aborted with err_len, and the FSM SHALL return to IDLE.
REQ-026 The in_stop bit SHALL move the FSM to DONE; blk_done and blk_crc_ok SHALL be asserted for exactly one cycle, one cycle after the stop bit; DONE SHALL return to IDLE the next cycle.
REQ-027 While in DONE, a bit presented with in_start=1 SHALL be accepted as the first bit of the next block, so that back-to-back blocks need no gap.
REQ-028 in_start received mid-block SHALL terminate the current block: blk_done with blk_crc_ok=0 and an err_proto pulse, and the new bit SHALL be accepted as a new block's first bit.
REQ-029 A bit with in_start and in_stop both high SHALL pulse err_proto and blk_done with blk_crc_ok=0, and the FSM SHALL return to IDLE.
REQ-030 in_valid=0 in any state SHALL hold all state, and tb_valid, blk_done, err_len and err_proto SHALL be 0 on the following cycle.

Reset
REQ-031 While reset=0, all outputs SHALL be 0, the FSM SHALL be IDLE, and the counter, LFSR and latched size SHALL be 0.
REQ-032 Assertion of reset mid-block SHALL discard the partial block with no blk_done.
REQ-033 The first bit accepted after reset deasserts SHALL require in_start.

Verification
REQ-034 in_size=0; 16 data bits all 0; 24 CRC bits all 0; in_stop on bit 40 -> 16 tb_valid pulses with tb_data=0, then blk_done=1, blk_crc_ok=1, err_len=0.
REQ-035 Same block as REQ-034 with CRC bit 5 set to 1 -> 16 data bits output, then blk_done=1, blk_crc_ok=0.
REQ-036 8 filler bits (in_data=1), 8 data bits, then 24 CRC bits computed from a reference model with filler treated as 0 -> only the 8 data bits appear on tb_data, blk_crc_ok=1.
REQ-037 Valid 40-bit block with in_valid toggled 0/1 every cycle -> identical tb_data sequence and blk_crc_ok=1, with no outputs asserted on stall cycles.
REQ-038 Block with in_stop on bit 39 -> err_len=1 and blk_crc_ok=0 with blk_done; a following valid block -> blk_crc_ok=1.
REQ-039 in_start asserted at bit 20 of a block -> err_proto=1 and blk_done with blk_crc_ok=0; the new block then completes with blk_crc_ok=1. Also: reset=0 at bit 10 -> no blk_done and all outputs 0.

Source files
------------

// File: rtl/cb_deseg.sv
// cb_deseg: receive-side inverse of code block segmentation.
// Strips filler bits, checks and strips the CRC24B, and forwards data bits serially.
// Each block is framed by in_start / in_stop, and every bit carries a filler or CRC flag.
module cb_deseg #(
    parameter int unsigned K_SMALL = 40,
    parameter int unsigned K_LARGE = 6144
) (
    input  logic clk,
    input  logic reset,
    input  logic in_data,
    input  logic in_valid,
    input  logic in_start,
    input  logic in_stop,
    input  logic in_filling,
    input  logic in_crc,
    input  logic in_size,
    output logic tb_data,
    output logic tb_valid,
    output logic blk_done,
    output logic blk_crc_ok,
    output logic err_len,
    output logic err_proto
);

    typedef enum logic [2:0] {StIdle, StFill, StData, StCrc, StDone} state_e;

    // CRC24B taps without the implicit x^24 term: x^23 + x^6 + x^5 + x + 1
    localparam logic [23:0] CrcPoly = 24'h800063;
    localparam logic [12:0] KSmall  = 13'(K_SMALL);
    localparam logic [12:0] KLarge  = 13'(K_LARGE);
    localparam logic [12:0] KAbort  = 13'(K_LARGE + 1);

    state_e      state_q;
    logic [12:0] cnt_q, cnt_d;
    logic [23:0] lfsr_q, lfsr_d;
    logic [4:0]  crc_cnt_q, crc_cnt_d;
    logic        size_q, size_d;
    logic        perr_q, perr_d;

    logic        in_block, is_data, order_err, bit_err, bit_val;
    logic [23:0] lfsr_base;
    logic [12:0] cnt_base;
    logic [4:0]  crc_cnt_base;
    logic [12:0] k_sel;

    // One serial step of the MSB-first division LFSR
    function automatic logic [23:0] crc_step(input logic [23:0] c, input logic b);
        logic fb;
        fb = c[23] ^ b;
        return {c[22:0], 1'b0} ^ (fb ? CrcPoly : 24'd0);
    endfunction

    // Classify the incoming bit and compute the block state it would produce if accepted
    always_comb begin
        in_block  = (state_q == StFill) || (state_q == StData) || (state_q == StCrc);
        is_data   = ~in_filling & ~in_crc;
        bit_val   = in_data & ~in_filling;
        order_err = 1'b0;
        if (!in_start) begin
            unique case (state_q)
                StData:  order_err = in_filling;
                StCrc:   order_err = in_filling | ~in_crc;
                default: order_err = 1'b0;
            endcase
        end
        bit_err = (in_filling & in_crc) | order_err;

        // A start bit begins from a clean slate, otherwise extend the running block
        lfsr_base    = in_start ? 24'd0 : lfsr_q;
        cnt_base     = in_start ? 13'd0 : cnt_q;
        crc_cnt_base = in_start ? 5'd0 : crc_cnt_q;
        perr_d       = (in_start ? 1'b0 : perr_q) | bit_err;
        size_d       = in_start ? in_size : size_q;

        lfsr_d = crc_step(lfsr_base, bit_val);
        cnt_d  = cnt_base + 13'd1;
        // Saturates so an overlong CRC run can never wrap back to 24
        if (in_crc && !in_filling && crc_cnt_base != 5'd31) begin
            crc_cnt_d = crc_cnt_base + 5'd1;
        end else begin
            crc_cnt_d = crc_cnt_base;
        end
        k_sel = size_d ? KLarge : KSmall;
    end

    // FSM, block state and registered outputs; nothing changes on stalled cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            lfsr_q     <= '0;
            crc_cnt_q  <= '0;
            size_q     <= 1'b0;
            perr_q     <= 1'b0;
            tb_data    <= 1'b0;
            tb_valid   <= 1'b0;
            blk_done   <= 1'b0;
            blk_crc_ok <= 1'b0;
            err_len    <= 1'b0;
            err_proto  <= 1'b0;
        end else begin
            tb_data    <= 1'b0;
            tb_valid   <= 1'b0;
            blk_done   <= 1'b0;
            blk_crc_ok <= 1'b0;
            err_len    <= 1'b0;
            err_proto  <= 1'b0;
            if (in_valid) begin
                if (!in_start && !in_block) begin
                    // Outside a block only a start bit is meaningful
                    err_proto <= 1'b1;
                    state_q   <= StIdle;
                end else if (in_start && in_stop) begin
                    err_proto <= 1'b1;
                    blk_done  <= 1'b1;
                    state_q   <= StIdle;
                end else begin
                    cnt_q     <= cnt_d;
                    lfsr_q    <= lfsr_d;
                    crc_cnt_q <= crc_cnt_d;
                    size_q    <= size_d;
                    perr_q    <= perr_d;
                    // A start inside a block closes the old block as failed
                    if (in_start && in_block) begin
                        blk_done  <= 1'b1;
                        err_proto <= 1'b1;
                    end
                    if (bit_err) begin
                        err_proto <= 1'b1;
                    end
                    if (is_data && !bit_err) begin
                        tb_valid <= 1'b1;
                        tb_data  <= in_data;
                    end
                    if (in_stop) begin
                        state_q    <= StDone;
                        blk_done   <= 1'b1;
                        blk_crc_ok <= (lfsr_d == 24'd0) && !perr_d && (crc_cnt_d == 5'd24) &&
                                      (cnt_d == k_sel);
                        err_len    <= (cnt_d != k_sel);
                    end else if (cnt_d == KAbort) begin
                        err_len <= 1'b1;
                        state_q <= StIdle;
                    end else if (!bit_err) begin
                        state_q <= in_filling ? StFill : (in_crc ? StCrc : StData);
                    end else if (in_start) begin
                        state_q <= StFill;
                    end
                end
            end
        end
    end

endmodule
